// File: rtl/dcache_mem_responder.sv
// ---------------------------------------------------------------------------
// dcache_mem_responder
//
// Main-memory model for the data cache's 256-bit line refill / write-back
// port. It accepts one line request at a time, waits a fixed access latency,
// then either returns the stored line (read) or commits the write-back line
// (write), signalling completion with a single-cycle ack.
//
// Handshake: the cache raises mem_enable_i with mem_write_i, mem_addr_i and
// mem_data_i and holds mem_enable_i high until it sees mem_ack_o. The request
// is captured on the first rising edge that finds mem_enable_i high in IDLE;
// later changes on the request inputs are ignored. Dropping mem_enable_i
// before the ack abandons the request: no write happens and no ack is given.
// mem_ack_o is high for exactly one cycle, the LATENCY-th cycle after the
// capture edge; mem_data_o carries the read line only in that cycle and is
// zero in every other cycle.
//
// Parameters:
//   DEPTH       number of lines stored (power of two)
//   LATENCY     cycles from capture to ack, 2..255
//   LINE_BITS   line width in bits
//   OFFSET_BITS byte-offset bits ignored inside a line address
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active low (storage is not cleared)
//   mem_enable_i  request valid, held until ack
//   mem_write_i   1 = write line, 0 = read line
//   mem_addr_i    byte address of the line
//   mem_data_i    write-back line
//   mem_data_o    read line, valid only while mem_ack_o is high
//   mem_ack_o     one-cycle completion pulse
//   err_o         (DMEM_RANGE_CHECK_EN only) sticky out-of-range flag
//   dbg_state_o   current FSM state: 0 IDLE, 1 WAIT, 2 ACK
//
// Build option:
//   DMEM_RANGE_CHECK_EN  when defined, requests with nonzero address bits
//   above the line index still complete normally, but reads return zero,
//   writes are dropped and err_o is set (cleared only by reset). When not
//   defined, those upper bits are ignored and addresses wrap modulo DEPTH.
// ---------------------------------------------------------------------------
module dcache_mem_responder #(
   parameter int DEPTH       = 512,
   parameter int LATENCY     = 10,
   parameter int LINE_BITS   = 256,
   parameter int OFFSET_BITS = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 mem_enable_i,
   input  logic                 mem_write_i,
   input  logic [31:0]          mem_addr_i,
   input  logic [LINE_BITS-1:0] mem_data_i,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic                 mem_ack_o,
`ifdef DMEM_RANGE_CHECK_EN
   output logic                 err_o,
`endif
   output logic [1:0]           dbg_state_o
);

   localparam int         IDX_BITS = $clog2(DEPTH);
   localparam int         HI_LSB   = OFFSET_BITS + IDX_BITS;
   // Last WAIT count; the edge that ends this count moves to ACK.
   localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t                state_q;
   logic [7:0]            cnt_q;
   logic [IDX_BITS-1:0]   idx_q;
   logic                  wr_q;
   logic [LINE_BITS-1:0]  wdata_q;
   logic                  oor_q;     // captured request lies outside storage

   logic [LINE_BITS-1:0]  mem [DEPTH];

   logic [IDX_BITS-1:0]   req_idx;
   logic                  req_oor;
   logic                  commit;
   logic                  unused_addr_bits;

   assign req_idx = mem_addr_i[HI_LSB-1:OFFSET_BITS];

`ifdef DMEM_RANGE_CHECK_EN
   assign req_oor          = |mem_addr_i[31:HI_LSB];
   assign unused_addr_bits = ^mem_addr_i[OFFSET_BITS-1:0];
`else
   // Upper address bits are ignored so the line index wraps modulo DEPTH.
   assign req_oor          = 1'b0;
   assign unused_addr_bits = ^{mem_addr_i[31:HI_LSB], mem_addr_i[OFFSET_BITS-1:0]};
`endif

   // The write lands on the edge that ends the ACK cycle. An asynchronous
   // reset forces the state back to IDLE first, so a reset request never
   // reaches storage.
   assign commit = (state_q == S_ACK) && wr_q && !oor_q;

   assign dbg_state_o = state_q;

   // -------------------------------------------------------------------------
   // Request FSM with registered ack / read-data outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         oor_q      <= 1'b0;
         mem_ack_o  <= 1'b0;
         mem_data_o <= '0;
`ifdef DMEM_RANGE_CHECK_EN
         err_o      <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               mem_ack_o  <= 1'b0;
               mem_data_o <= '0;
               if (mem_enable_i) begin
                  idx_q   <= req_idx;
                  wr_q    <= mem_write_i;
                  wdata_q <= mem_data_i;
                  oor_q   <= req_oor;
                  cnt_q   <= 8'd1;
                  state_q <= S_WAIT;
               end
            end

            S_WAIT: begin
               // Abort wins over completion so a request dropped in its
               // final wait cycle is still abandoned.
               if (!mem_enable_i) begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  cnt_q     <= '0;
                  state_q   <= S_ACK;
                  mem_ack_o <= 1'b1;
                  // Read data is fetched on the edge entering ACK so it is
                  // presented from a register for the whole ack cycle.
                  if (wr_q || oor_q) begin
                     mem_data_o <= '0;
                  end else begin
                     mem_data_o <= mem[idx_q];
                  end
`ifdef DMEM_RANGE_CHECK_EN
                  if (oor_q) begin
                     err_o <= 1'b1;
                  end
`endif
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            S_ACK: begin
               mem_ack_o  <= 1'b0;
               mem_data_o <= '0;
               state_q    <= S_IDLE;
            end

            default: begin
               mem_ack_o  <= 1'b0;
               mem_data_o <= '0;
               cnt_q      <= '0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Line storage; deliberately not reset so contents survive rst_i
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (commit) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_dcache_mem_responder.sv
`timescale 1ns/1ps
module tb_dcache_mem_responder;

   localparam int LAT   = 10;
   localparam int DEPTH = 512;
   localparam int LB    = 256;

   localparam logic [LB-1:0] LINE_DB  = {8{32'hDEADBEEF}};
   localparam logic [LB-1:0] LINE_7A  = {8{32'hA5A50007}};
   localparam logic [LB-1:0] LINE_7B  = {8{32'h5A5A7777}};
   localparam logic [LB-1:0] LINE_D0  = {8{32'h0000D00D}};
   localparam logic [LB-1:0] LINE_C   = {8{32'hC0DE4000}};
   localparam logic [LB-1:0] LINE_F   = {8{32'h0F0F0009}};
   localparam logic [LB-1:0] LINE_G   = {8{32'h60600014}};

   // ---------------------------------------------------------------- clock/reset
   logic          clk = 1'b0;
   logic          rst_i;
   logic          mem_enable_i;
   logic          mem_write_i;
   logic [31:0]   mem_addr_i;
   logic [LB-1:0] mem_data_i;
   logic [LB-1:0] mem_data_o;
   logic          mem_ack_o;
   logic [1:0]    dbg_state_o;
`ifdef DMEM_RANGE_CHECK_EN
   logic          err_o;
`endif

   always #5 clk = ~clk;

   dcache_mem_responder dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .mem_enable_i (mem_enable_i),
      .mem_write_i  (mem_write_i),
      .mem_addr_i   (mem_addr_i),
      .mem_data_i   (mem_data_i),
      .mem_data_o   (mem_data_o),
      .mem_ack_o    (mem_ack_o),
`ifdef DMEM_RANGE_CHECK_EN
      .err_o        (err_o),
`endif
      .dbg_state_o  (dbg_state_o)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- scoreboard
   int checks   = 0;
   int failures = 0;
   logic [LB-1:0] exp_q[$];

   task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   // Memory seen as an array of lines indexed by address / line size, with a
   // flag per line telling whether its contents are known.
   logic [LB-1:0] ref_mem   [DEPTH];
   bit            ref_valid [DEPTH];

   function automatic int line_of(input logic [31:0] a);
      return int'((a / 32'd32) % 32'(DEPTH));
   endfunction

   function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
      return (a / 32'd32) >= 32'(DEPTH);
`else
      return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
   endfunction

   function automatic logic [LB-1:0] rand_line();
      logic [LB-1:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // ---------------------------------------------------------------- driver tasks
   // Issues one request starting now (just after an edge, DUT in IDLE) and
   // watches LAT+3 cycles. Cycle 1 is the cycle after the capture edge.
   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [LB-1:0] wdata,
                         input int abort_at, input int scramble_at,
                         output int ack_cyc, output int n_ack, output int stray,
                         output logic [LB-1:0] rdata);
      mem_enable_i = 1'b1;
      mem_write_i  = wr;
      mem_addr_i   = addr;
      mem_data_i   = wdata;
      ack_cyc = -1;
      n_ack   = 0;
      stray   = 0;
      rdata   = '0;
      for (int c = 1; c <= LAT + 3; c++) begin
         @(posedge clk); #1;
         if (mem_ack_o) begin
            n_ack++;
            if (ack_cyc < 0) begin
               ack_cyc = c;
               rdata   = mem_data_o;
            end
            mem_enable_i = 1'b0;
         end else if (mem_data_o != '0) begin
            stray++;
         end
         if (c == abort_at) mem_enable_i = 1'b0;
         if (c == scramble_at) begin
            mem_addr_i  = $urandom;
            mem_data_i  = rand_line();
            mem_write_i = ~wr;
         end
      end
      mem_enable_i = 1'b0;
   endtask

   // Runs one request and compares against the given expectations; the model
   // is updated when a write is expected to complete.
   task automatic apply(input string name, input bit wr, input logic [31:0] addr,
                        input logic [LB-1:0] wdata, input int abort_at, input int scramble_at,
                        input int exp_ack_cyc, input logic [LB-1:0] exp_data, input bit chk_data);
      int ack_cyc, n_ack, stray;
      logic [LB-1:0] rdata;
      if (chk_data) exp_q.push_back(exp_data);
      do_txn(wr, addr, wdata, abort_at, scramble_at, ack_cyc, n_ack, stray, rdata);
      chk_int({name, " ack_cycle"}, ack_cyc, exp_ack_cyc);
      chk_int({name, " ack_count"}, n_ack, (exp_ack_cyc > 0) ? 1 : 0);
      chk_int({name, " data_outside_ack"}, stray, 0);
      if (chk_data) chk({name, " data"}, rdata, exp_q.pop_front());
      if (exp_ack_cyc > 0 && wr && !out_of_range(addr)) begin
         ref_mem[line_of(addr)]   = wdata;
         ref_valid[line_of(addr)] = 1'b1;
      end
   endtask

   // ---------------------------------------------------------------- vector table
   typedef struct {
      bit            wr;
      logic [31:0]   addr;
      logic [LB-1:0] wdata;
      int            abort_at;
      int            scramble_at;
      int            exp_ack;
      logic [LB-1:0] exp_data;
      bit            chk_data;
      int            exp_err;
   } vec_t;

   vec_t tbl[10];

   // ---------------------------------------------------------------- test
   initial begin
      int ack_cyc, n_ack, stray;
      logic [LB-1:0] rdata, rdata2;
      int ack1, ack2, acks;

      tbl[0] = '{1'b1, 32'h0000_0400, LINE_DB, 0, 0, LAT, '0,      1'b1, 0};
      tbl[1] = '{1'b0, 32'h0000_0410, '0,      0, 3, LAT, LINE_DB, 1'b1, 0};
      tbl[2] = '{1'b1, 32'h0000_00E0, LINE_7A, 0, 0, LAT, '0,      1'b1, 0};
      tbl[3] = '{1'b1, 32'h0000_00E0, LINE_7B, 4, 0, -1,  '0,      1'b0, 0};
      tbl[4] = '{1'b0, 32'h0000_00E8, '0,      0, 0, LAT, LINE_7A, 1'b1, 0};
      tbl[5] = '{1'b1, 32'h0000_0000, LINE_D0, 0, 0, LAT, '0,      1'b1, 0};
      tbl[6] = '{1'b1, 32'h0000_4000, LINE_C,  0, 0, LAT, '0,      1'b1, 1};
`ifdef DMEM_RANGE_CHECK_EN
      tbl[7] = '{1'b0, 32'h0000_0000, '0,      0, 0, LAT, LINE_D0, 1'b1, 1};
      tbl[8] = '{1'b0, 32'h0000_4000, '0,      0, 0, LAT, '0,      1'b1, 1};
`else
      tbl[7] = '{1'b0, 32'h0000_0000, '0,      0, 0, LAT, LINE_C,  1'b1, 1};
      tbl[8] = '{1'b0, 32'h0000_4000, '0,      0, 0, LAT, LINE_C,  1'b1, 1};
`endif
      tbl[9] = '{1'b0, 32'h0000_0400, '0,      0, 5, LAT, LINE_DB, 1'b1, 1};

      // Reset held low for 3 cycles with a request pending.
      rst_i        = 1'b0;
      mem_enable_i = 1'b1;
      mem_write_i  = 1'b0;
      mem_addr_i   = 32'h0000_0400;
      mem_data_i   = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_int("reset ack", int'(mem_ack_o), 0);
         chk("reset data", mem_data_o, '0);
         chk_int("reset state", int'(dbg_state_o), 0);
`ifdef DMEM_RANGE_CHECK_EN
         chk_int("reset err", int'(err_o), 0);
`endif
      end
      rst_i = 1'b1;
      ack_cyc = -1;
      n_ack   = 0;
      for (int c = 1; c <= LAT + 3; c++) begin
         @(posedge clk); #1;
         if (mem_ack_o) begin
            n_ack++;
            if (ack_cyc < 0) ack_cyc = c;
            mem_enable_i = 1'b0;
         end
      end
      mem_enable_i = 1'b0;
      chk_int("post_reset ack_cycle", ack_cyc, LAT);
      chk_int("post_reset ack_count", n_ack, 1);

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         apply($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
               tbl[i].abort_at, tbl[i].scramble_at, tbl[i].exp_ack, tbl[i].exp_data,
               tbl[i].chk_data);
`ifdef DMEM_RANGE_CHECK_EN
         chk_int($sformatf("tbl%0d err", i), int'(err_o), tbl[i].exp_err);
`endif
      end

      // Reset in the middle of a write: nothing written, no ack.
      apply("rst_mid setup", 1'b1, 32'h0000_0120, LINE_F, 0, 0, LAT, '0, 1'b1);
      mem_enable_i = 1'b1;
      mem_write_i  = 1'b1;
      mem_addr_i   = 32'h0000_0120;
      mem_data_i   = LINE_G;
      repeat (5) @(posedge clk);
      #1;
      rst_i = 1'b0;
      #1;
      chk_int("rst_mid ack", int'(mem_ack_o), 0);
      chk_int("rst_mid state", int'(dbg_state_o), 0);
      @(posedge clk); #1;
      mem_enable_i = 1'b0;
      rst_i        = 1'b1;
      n_ack = 0;
      for (int c = 0; c < LAT + 3; c++) begin
         @(posedge clk); #1;
         if (mem_ack_o) n_ack++;
      end
      chk_int("rst_mid no_ack", n_ack, 0);
      apply("rst_mid readback", 1'b0, 32'h0000_0130, '0, 0, 0, LAT, LINE_F, 1'b1);

      // Back-to-back: enable held through the ack; second request is a read
      // of the line the first one wrote.
      mem_enable_i = 1'b1;
      mem_write_i  = 1'b1;
      mem_addr_i   = 32'h0000_0280;
      mem_data_i   = LINE_G;
      ack1 = -1;
      ack2 = -1;
      acks = 0;
      rdata2 = '0;
      for (int c = 1; c <= 2 * LAT + 4; c++) begin
         @(posedge clk); #1;
         if (mem_ack_o) begin
            acks++;
            if (ack1 < 0) begin
               ack1 = c;
               mem_write_i = 1'b0;
               mem_addr_i  = 32'h0000_0290;
               mem_data_i  = rand_line();
            end else if (ack2 < 0) begin
               ack2   = c;
               rdata2 = mem_data_o;
               mem_enable_i = 1'b0;
            end
         end
      end
      mem_enable_i = 1'b0;
      ref_mem[line_of(32'h0000_0280)]   = LINE_G;
      ref_valid[line_of(32'h0000_0280)] = 1'b1;
      chk_int("b2b first_ack", ack1, LAT);
      chk_int("b2b second_ack", ack2, 2 * LAT + 1);
      chk_int("b2b ack_count", acks, 2);
      chk("b2b read_after_write", rdata2, LINE_G);

      // Randomised traffic against the model.
      for (int t = 0; t < 40; t++) begin
         bit            wr, oor;
         logic [31:0]   addr;
         logic [LB-1:0] wd, ed;
         int            ab, sc, ln;
         bit            cd;
         wr   = 1'($urandom_range(0, 1));
         addr = (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
         if ($urandom_range(0, 4) == 0) addr = addr | (32'($urandom_range(1, 3)) << 14);
         wd   = rand_line();
         ab   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, LAT - 1) : 0;
         sc   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT - 1) : 0;
         oor  = out_of_range(addr);
         ln   = line_of(addr);
         if (ab != 0) begin
            ed = '0;
            cd = 1'b0;
         end else if (wr || oor) begin
            ed = '0;
            cd = 1'b1;
         end else begin
            ed = ref_mem[ln];
            cd = ref_valid[ln];
         end
         apply($sformatf("rand%0d", t), wr, addr, wd, ab, sc, (ab != 0) ? -1 : LAT, ed, cd);
      end

      // Final reset clears outputs (and the sticky error flag).
      rst_i = 1'b0;
      #1;
      chk_int("final_reset ack", int'(mem_ack_o), 0);
      chk("final_reset data", mem_data_o, '0);
`ifdef DMEM_RANGE_CHECK_EN
      chk_int("final_reset err", int'(err_o), 0);
`endif
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
